instruction_register: RTL and testbench

INSTRUCTION_REGISTER -- requirements
Module: instruction_register

---
 rtl/instruction_register_pkg.sv | 27 ++
 rtl/instruction_register_field_split.sv | 36 +++
 rtl/instruction_register.sv | 137 +++++++++++++
 tb/tb_instruction_register.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_register_pkg.sv
// ----------------------------------------------------------------------------
// instruction_register_pkg
// Shared definitions for the instruction register and the decode paths that
// reuse its field splitter: FSM state encoding, instruction field widths,
// the NOP word and a byte-reversal helper for little-endian memory buses.
// ----------------------------------------------------------------------------
package instruction_register_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } ir_state_t;

    localparam int OPCODE_W  = 6;
    localparam int REG_W     = 5;
    localparam int IMM_W     = 16;
    localparam int JTARGET_W = 26;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/instruction_register_field_split.sv
// ----------------------------------------------------------------------------
// instr_field_split
// Purely combinational slicing of a 32-bit instruction word into its fields.
// Ports:
//   instr           in  32  instruction word
//   opcode          out  6  instr[31:26]
//   rs, rt, rd      out  5  instr[25:21], instr[20:16], instr[15:11]
//   shamt           out  5  instr[10:6]
//   funct           out  6  instr[5:0]
//   itype_immediate out 16  instr[15:0], not extended
//   jtarget         out 26  instr[25:0]
// ----------------------------------------------------------------------------
module instr_field_split
    import instruction_register_pkg::*;
(
    input  logic [31:0]          instr,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [REG_W-1:0]     rs,
    output logic [REG_W-1:0]     rt,
    output logic [REG_W-1:0]     rd,
    output logic [REG_W-1:0]     shamt,
    output logic [5:0]           funct,
    output logic [IMM_W-1:0]     itype_immediate,
    output logic [JTARGET_W-1:0] jtarget
);

    assign opcode          = instr[31:26];
    assign rs              = instr[25:21];
    assign rt              = instr[20:16];
    assign rd              = instr[15:11];
    assign shamt           = instr[10:6];
    assign funct           = instr[5:0];
    assign itype_immediate = instr[15:0];
    assign jtarget         = instr[25:0];

endmodule

// File: rtl/instruction_register.sv
// ----------------------------------------------------------------------------
// instruction_register
// Fetches one instruction word over a waitrequest-style memory read port,
// holds it until the consumer acknowledges, and exposes its decoded fields.
// A misaligned fetch pc raises a sticky fault that only reset clears.
//
// State table:
//   state    | meaning
//   IDLE     | waiting for fetch_en
//   REQ      | read in flight at the latched address, stalls on waitrequest
//   HOLD     | instr is valid, waiting for instr_ack
//   FAULT    | misaligned pc seen; parked until reset
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   fetch_en, pc        fetch request and byte address
//   instr_ack           consumer has used the held word
//   address, read       memory word address and read strobe
//   waitrequest         memory stall
//   readdata            memory read data
//   instr, instr_valid  held instruction word and its valid flag
//   opcode..jtarget     field slices of instr
//   fetch_fault         sticky misaligned-pc flag
//
// Build option: INSTR_BYTE_SWAP_EN reverses the byte order of readdata
// before it is loaded into instr (little-endian memory bus).
// ----------------------------------------------------------------------------
module instruction_register
    import instruction_register_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_en,
    input  logic [31:0]          pc,
    input  logic                 instr_ack,
    output logic [31:0]          address,
    output logic                 read,
    input  logic                 waitrequest,
    input  logic [31:0]          readdata,
    output logic [31:0]          instr,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [REG_W-1:0]     rs,
    output logic [REG_W-1:0]     rt,
    output logic [REG_W-1:0]     rd,
    output logic [REG_W-1:0]     shamt,
    output logic [5:0]           funct,
    output logic [IMM_W-1:0]     itype_immediate,
    output logic [JTARGET_W-1:0] jtarget,
    output logic                 instr_valid,
    output logic                 fetch_fault
);

    ir_state_t   r_state;
    logic [31:0] r_addr;
    logic [31:0] r_instr;
    logic        r_fault;

    logic [31:0] w_load_word;
    logic        w_pc_aligned;

`ifdef INSTR_BYTE_SWAP_EN
    assign w_load_word = byte_swap32(readdata);
`else
    assign w_load_word = readdata;
`endif

    assign w_pc_aligned = (pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= 32'h0000_0000;
            r_instr <= NOP;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fetch_en) begin
                        if (w_pc_aligned) begin
                            r_addr  <= pc;
                            r_state <= ST_REQ;
                        end else begin
                            r_fault <= 1'b1;
                            r_state <= ST_FAULT;
                        end
                    end
                end
                ST_REQ: begin
                    if (!waitrequest) begin
                        r_instr <= w_load_word;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Acknowledge with a new request chains straight into
                    // the next read without an IDLE bubble.
                    if (instr_ack) begin
                        if (fetch_en && w_pc_aligned) begin
                            r_addr  <= pc;
                            r_state <= ST_REQ;
                        end else if (fetch_en) begin
                            r_fault <= 1'b1;
                            r_state <= ST_FAULT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign address     = {r_addr[31:2], 2'b00};
    assign read        = (r_state == ST_REQ);
    assign instr_valid = (r_state == ST_HOLD);
    assign fetch_fault = r_fault;
    assign instr       = r_instr;

    instr_field_split u_field_split (
        .instr           (r_instr),
        .opcode          (opcode),
        .rs              (rs),
        .rt              (rt),
        .rd              (rd),
        .shamt           (shamt),
        .funct           (funct),
        .itype_immediate (itype_immediate),
        .jtarget         (jtarget)
    );

endmodule

// File: tb/tb_instruction_register.sv
module tb_instruction_register;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic [31:0] pc;
    logic        instr_ack;
    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] itype_immediate;
    logic [25:0] jtarget;
    logic        instr_valid;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_register dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .pc              (pc),
        .instr_ack       (instr_ack),
        .address         (address),
        .read            (read),
        .waitrequest     (waitrequest),
        .readdata        (readdata),
        .instr           (instr),
        .opcode          (opcode),
        .rs              (rs),
        .rt              (rt),
        .rd              (rd),
        .shamt           (shamt),
        .funct           (funct),
        .itype_immediate (itype_immediate),
        .jtarget         (jtarget),
        .instr_valid     (instr_valid),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory presents the word so that, after any configured byte reversal,
    // the captured instruction equals the logical value in the table.
    function automatic logic [31:0] mem_word(input logic [31:0] logical);
`ifdef INSTR_BYTE_SWAP_EN
        return {logical[7:0], logical[15:8], logical[23:16], logical[31:24]};
`else
        return logical;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        fen;
        logic [31:0] pc;
        logic        ack;
        logic        wr;
        logic [31:0] rdata;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic        e_read;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_instr;
    } vec_t;

    localparam logic [31:0] W_LUI = 32'h3C01_1234;
    localparam logic [31:0] W_LW  = 32'h8C22_0004;
    localparam logic [31:0] W_ADD = 32'h0043_0820;
    localparam logic [31:0] W_ORI = 32'h3421_00FF;

    vec_t vecs[$];

    initial begin
        int n;
        reset = 1'b1; fetch_en = 1'b0; pc = '0; instr_ack = 1'b0;
        waitrequest = 1'b0; readdata = '0;

        //           rst  fen  pc      ack  wr   rdata          ca  e_addr  rd  vl  ft  e_instr
        vecs.push_back('{1, 0, 32'h00, 0, 0, 32'h0,          1, 32'h00, 0, 0, 0, 32'h0});
        // zero-wait fetch
        vecs.push_back('{0, 1, 32'h10, 0, 0, 32'h0,          1, 32'h10, 1, 0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h10, 0, 0, W_LUI,          1, 32'h10, 0, 1, 0, W_LUI});
        vecs.push_back('{0, 0, 32'h10, 0, 0, 32'h0,          1, 32'h10, 0, 1, 0, W_LUI});
        vecs.push_back('{0, 0, 32'h10, 1, 0, 32'h0,          1, 32'h10, 0, 0, 0, W_LUI});
        // three wait states, pc moves mid-request
        vecs.push_back('{0, 1, 32'h10, 0, 0, 32'h0,          1, 32'h10, 1, 0, 0, W_LUI});
        vecs.push_back('{0, 0, 32'h20, 0, 1, 32'hDEADBEEF,   1, 32'h10, 1, 0, 0, W_LUI});
        vecs.push_back('{0, 1, 32'h20, 0, 1, 32'hDEADBEEF,   1, 32'h10, 1, 0, 0, W_LUI});
        vecs.push_back('{0, 1, 32'h24, 1, 1, 32'hDEADBEEF,   1, 32'h10, 1, 0, 0, W_LUI});
        vecs.push_back('{0, 0, 32'h20, 0, 0, W_LW,           1, 32'h10, 0, 1, 0, W_LW});
        // back-to-back: ack with a new aligned fetch
        vecs.push_back('{0, 1, 32'h14, 1, 0, 32'h0,          1, 32'h14, 1, 0, 0, W_LW});
        vecs.push_back('{0, 0, 32'h14, 0, 0, W_ADD,          1, 32'h14, 0, 1, 0, W_ADD});
        vecs.push_back('{0, 1, 32'h18, 0, 0, 32'h0,          1, 32'h14, 0, 1, 0, W_ADD});
        // reset mid-request discards the read
        vecs.push_back('{0, 1, 32'h18, 1, 1, 32'h0,          1, 32'h18, 1, 0, 0, W_ADD});
        vecs.push_back('{1, 0, 32'h18, 0, 0, 32'hFFFFFFFF,   0, 32'h00, 0, 0, 0, 32'h0});
        // misaligned from IDLE, sticky until reset
        vecs.push_back('{0, 1, 32'h12, 0, 0, 32'h0,          0, 32'h00, 0, 0, 1, 32'h0});
        vecs.push_back('{0, 1, 32'h10, 0, 0, 32'h0,          0, 32'h00, 0, 0, 1, 32'h0});
        vecs.push_back('{0, 0, 32'h10, 1, 0, W_LUI,          0, 32'h00, 0, 0, 1, 32'h0});
        vecs.push_back('{1, 1, 32'h10, 0, 0, 32'h0,          0, 32'h00, 0, 0, 0, 32'h0});
        // ack ignored in IDLE, then misaligned chain from HOLD
        vecs.push_back('{0, 0, 32'h10, 1, 0, 32'h0,          0, 32'h00, 0, 0, 0, 32'h0});
        vecs.push_back('{0, 1, 32'h20, 0, 0, 32'h0,          1, 32'h20, 1, 0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h20, 0, 0, W_ORI,          1, 32'h20, 0, 1, 0, W_ORI});
        vecs.push_back('{0, 1, 32'h23, 1, 0, 32'h0,          1, 32'h20, 0, 0, 1, W_ORI});
        vecs.push_back('{0, 1, 32'h24, 1, 0, 32'h0,          1, 32'h20, 0, 0, 1, W_ORI});

        foreach (vecs[i]) begin
            reset       = vecs[i].rst;
            fetch_en    = vecs[i].fen;
            pc          = vecs[i].pc;
            instr_ack   = vecs[i].ack;
            waitrequest = vecs[i].wr;
            readdata    = mem_word(vecs[i].rdata);
            step();
            if (vecs[i].chk_addr)
                chk($sformatf("v%0d address", i), address, vecs[i].e_addr);
            chk($sformatf("v%0d read", i), {31'b0, read}, {31'b0, vecs[i].e_read});
            chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d fetch_fault", i), {31'b0, fetch_fault}, {31'b0, vecs[i].e_fault});
            chk($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
        end

        // Field decode of an I-type word after a zero-wait fetch.
        reset = 1'b1; fetch_en = 1'b0; instr_ack = 1'b0; waitrequest = 1'b0;
        step();
        reset = 1'b0; fetch_en = 1'b1; pc = 32'h10; readdata = mem_word(W_LUI);
        step();
        fetch_en = 1'b0;
        step();
        chk("lui valid",  {31'b0, instr_valid}, 32'd1);
        chk("lui opcode", {26'b0, opcode}, 32'h0F);
        chk("lui rs",     {27'b0, rs}, 32'd0);
        chk("lui rt",     {27'b0, rt}, 32'd1);
        chk("lui rd",     {27'b0, rd}, 32'd2);
        chk("lui shamt",  {27'b0, shamt}, 32'd8);
        chk("lui funct",  {26'b0, funct}, 32'h34);
        chk("lui imm",    {16'b0, itype_immediate}, 32'h1234);
        chk("lui jtgt",   {6'b0, jtarget}, 32'h0011234);

        // Chained fetch with two wait states; latency bounded by a cycle budget.
        instr_ack = 1'b1; fetch_en = 1'b1; pc = 32'h44; waitrequest = 1'b1;
        readdata = mem_word(W_ADD);
        step();
        chk("chain address", address, 32'h44);
        instr_ack = 1'b0; fetch_en = 1'b0;
        n = 1;
        while (!instr_valid && n < 10) begin
            if (n >= 3) waitrequest = 1'b0;
            step();
            n++;
        end
        chk("wait latency", n, 32'd4);
        chk("add instr",  instr, W_ADD);
        chk("add opcode", {26'b0, opcode}, 32'h00);
        chk("add rs",     {27'b0, rs}, 32'd2);
        chk("add rt",     {27'b0, rt}, 32'd3);
        chk("add rd",     {27'b0, rd}, 32'd1);
        chk("add shamt",  {27'b0, shamt}, 32'd0);
        chk("add funct",  {26'b0, funct}, 32'h20);
        chk("add jtgt",   {6'b0, jtarget}, 32'h0430820);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
